direct_mapped_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache that answers the CPU's MEM-stage load/store requests and refills lines from backing memory. The CPU drives `addr`, `din`, `mem_read` and `mem_write` from its EX/MEM registers and stalls on `is_ready`, `is_hit` and `is_output_valid`. Misses are served through a line-wide request/response port to the data memory model.

---
 rtl/direct_mapped_cache.sv | 176 +++++++++++++++++
 tb/tb_direct_mapped_cache.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the CPU MEM stage.
// Hits answer combinationally in IDLE; misses write back a dirty victim, then refill the whole line.
module direct_mapped_cache #(
   parameter int NUM_SETS   = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [31:0]                addr,
   input  logic [31:0]                din,
   input  logic                       mem_read,
   input  logic                       mem_write,
   output logic [31:0]                dout,
   output logic                       is_ready,
   output logic                       is_output_valid,
   output logic                       is_hit,
   output logic                       mem_req_valid,
   output logic                       mem_req_write,
   output logic [31:0]                mem_req_addr,
   output logic [LINE_WORDS*32-1:0]   mem_req_wdata,
   input  logic                       mem_req_ready,
   input  logic                       mem_resp_valid,
   input  logic [LINE_WORDS*32-1:0]   mem_resp_rdata
);

   localparam int LINE_BITS = LINE_WORDS * 32;
   localparam int IDX_W     = $clog2(NUM_SETS);
   localparam int TAG_W     = 32 - 4 - IDX_W;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WB        = 2'd1,
      S_FILL_REQ  = 2'd2,
      S_FILL_WAIT = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_SETS-1:0]   valid_q, valid_d;
   logic [NUM_SETS-1:0]   dirty_q, dirty_d;
   logic [TAG_W-1:0]      tag_q  [NUM_SETS];
   logic [LINE_BITS-1:0]  data_q [NUM_SETS];

   logic [IDX_W-1:0]      idx_s;
   logic [TAG_W-1:0]      tag_s;
   logic [1:0]            off_s;
   logic [LINE_BITS-1:0]  line_s;
   logic [31:0]           word_s;
   logic                  req_s;
   logic                  hit_s;
   logic                  data_we_s;
   logic                  tag_we_s;
   logic [LINE_BITS-1:0]  data_wline_s;
   logic [31:0]           dout_s;
   logic                  out_valid_s;
   logic                  req_valid_s;
   logic                  req_write_s;
   logic [31:0]           req_addr_s;
   logic [LINE_BITS-1:0]  req_wdata_s;
   logic                  unused_s;

   assign idx_s    = addr[4 +: IDX_W];
   assign tag_s    = addr[31 -: TAG_W];
   assign off_s    = addr[3:2];
   assign line_s   = data_q[idx_s];
   assign word_s   = line_s[{off_s, 5'b00000} +: 32];
   assign req_s    = mem_read | mem_write;
   assign hit_s    = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
   assign unused_s = ^addr[1:0];

   // Next-state, array update controls and all cache outputs
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      data_we_s    = 1'b0;
      tag_we_s     = 1'b0;
      data_wline_s = line_s;
      dout_s       = 32'h0000_0000;
      out_valid_s  = 1'b0;
      req_valid_s  = 1'b0;
      req_write_s  = 1'b0;
      req_addr_s   = 32'h0000_0000;
      req_wdata_s  = '0;
      case (state_q)
         S_IDLE: begin
            if (req_s) begin
               if (hit_s) begin
                  out_valid_s = 1'b1;
                  if (mem_write) begin
                     data_we_s                                  = 1'b1;
                     data_wline_s[{off_s, 5'b00000} +: 32]      = din;
                     dirty_d[idx_s]                             = 1'b1;
                  end else begin
                     dout_s = word_s;
                  end
               end else if (valid_q[idx_s] && dirty_q[idx_s]) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FILL_REQ;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WB: begin
            req_valid_s = 1'b1;
            req_write_s = 1'b1;
            req_addr_s  = {tag_q[idx_s], idx_s, 4'b0000};
            req_wdata_s = line_s;
            if (mem_req_ready) begin
               dirty_d[idx_s] = 1'b0;
               state_d        = S_FILL_REQ;
            end else begin
               state_d = S_WB;
            end
         end
         S_FILL_REQ: begin
            req_valid_s = 1'b1;
            req_addr_s  = {addr[31:4], 4'b0000};
            if (mem_req_ready) begin
               state_d = S_FILL_WAIT;
            end else begin
               state_d = S_FILL_REQ;
            end
         end
         S_FILL_WAIT: begin
            if (mem_resp_valid) begin
               data_we_s      = 1'b1;
               tag_we_s       = 1'b1;
               data_wline_s   = mem_resp_rdata;
               valid_d[idx_s] = 1'b1;
               dirty_d[idx_s] = 1'b0;
               state_d        = S_IDLE;
            end else begin
               state_d = S_FILL_WAIT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control state; reset drops any in-flight transaction and invalidates every line
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tag and data arrays carry no reset; valid bits gate their use
   always_ff @(posedge clk) begin
      if (data_we_s) begin
         data_q[idx_s] <= data_wline_s;
      end
      if (tag_we_s) begin
         tag_q[idx_s] <= tag_s;
      end
   end

   assign dout            = dout_s;
   assign is_ready        = (state_q == S_IDLE);
   assign is_output_valid = out_valid_s;
   assign is_hit          = hit_s;
   assign mem_req_valid   = req_valid_s;
   assign mem_req_write   = req_write_s;
   assign mem_req_addr    = req_addr_s;
   assign mem_req_wdata   = req_wdata_s;

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Self-checking bench for direct_mapped_cache: directed scenarios plus randomized loads/stores
// checked against a flat-memory golden model and a simple tag/valid/dirty reference.
module tb_direct_mapped_cache;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [31:0]  addr = 32'h0;
   logic [31:0]  din = 32'h0;
   logic         mem_read = 1'b0;
   logic         mem_write = 1'b0;
   logic [31:0]  dout;
   logic         is_ready, is_output_valid, is_hit;
   logic         mem_req_valid, mem_req_write;
   logic [31:0]  mem_req_addr;
   logic [127:0] mem_req_wdata;
   logic         mem_req_ready = 1'b0;
   logic         mem_resp_valid = 1'b0;
   logic [127:0] mem_resp_rdata = 128'h0;

   direct_mapped_cache dut (
      .clk(clk), .reset(reset), .addr(addr), .din(din),
      .mem_read(mem_read), .mem_write(mem_write), .dout(dout),
      .is_ready(is_ready), .is_output_valid(is_output_valid), .is_hit(is_hit),
      .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
      .mem_resp_rdata(mem_resp_rdata)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Backing memory contents and the CPU-visible golden view (word addressed by byte address)
   logic [31:0] mem_word [int unsigned];
   logic [31:0] gold     [int unsigned];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_word.exists(a)) return mem_word[a];
      return init_word(a);
   endfunction

   function automatic logic [31:0] gold_rd(input logic [31:0] a);
      if (gold.exists(a)) return gold[a];
      return init_word(a);
   endfunction

   bit          ref_valid [16];
   bit          ref_dirty [16];
   logic [23:0] ref_tag   [16];

   bit           manual = 1'b0;
   bit           fixed_timing = 1'b1;
   int           stall_left = 0;
   int           resp_wait = 0;
   logic [31:0]  fill_addr = 32'h0;
   bit           prev_stall = 1'b0;
   logic [31:0]  prev_addr;
   logic         prev_write;
   logic [127:0] prev_wdata;
   int           wb_count = 0;
   int           fill_count = 0;
   logic [31:0]  last_wb_addr = 32'h0;
   logic [127:0] last_wb_wdata = 128'h0;
   logic [31:0]  last_fill_addr = 32'h0;

   // Memory responder: handshakes at the falling edge, takes effect at the next rising edge
   initial begin
      forever begin
         @(negedge clk);
         if (!manual) begin
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b0;
            if (resp_wait > 0) begin
               resp_wait--;
               if (resp_wait == 0) begin
                  mem_resp_valid = 1'b1;
                  for (int w = 0; w < 4; w++) mem_resp_rdata[w*32 +: 32] = mem_rd(fill_addr + 32'(4 * w));
               end
            end
            if (mem_req_valid) begin
               check_eq("busy_not_ready", is_ready, 1'b0);
               check_eq("busy_no_complete", is_output_valid, 1'b0);
               check_eq("req_line_aligned", mem_req_addr[3:0], 4'h0);
               if (prev_stall) begin
                  check_eq("stall_addr_stable", mem_req_addr, prev_addr);
                  check_eq("stall_write_stable", mem_req_write, prev_write);
                  check_eq("stall_wdata_stable", mem_req_wdata, prev_wdata);
               end
               if (stall_left > 0) begin
                  stall_left--;
                  prev_stall = 1'b1;
                  prev_addr  = mem_req_addr;
                  prev_write = mem_req_write;
                  prev_wdata = mem_req_wdata;
               end else begin
                  mem_req_ready = 1'b1;
                  prev_stall    = 1'b0;
                  if (mem_req_write) begin
                     wb_count++;
                     last_wb_addr  = mem_req_addr;
                     last_wb_wdata = mem_req_wdata;
                     for (int w = 0; w < 4; w++) begin
                        check_eq("wb_data", mem_req_wdata[w*32 +: 32], gold_rd(mem_req_addr + 32'(4 * w)));
                        mem_word[mem_req_addr + 32'(4 * w)] = mem_req_wdata[w*32 +: 32];
                     end
                  end else begin
                     fill_count++;
                     last_fill_addr = mem_req_addr;
                     fill_addr      = mem_req_addr;
                     resp_wait      = fixed_timing ? 2 : int'($urandom_range(1, 4));
                  end
                  stall_left = fixed_timing ? 0 : int'($urandom_range(0, 2));
               end
            end else begin
               prev_stall = 1'b0;
               check_eq("req_idle_zero", {mem_req_write, mem_req_addr, mem_req_wdata}, 161'h0);
            end
         end
      end
   end

   task automatic access(input bit st, input logic [31:0] a, input logic [31:0] d, output int cyc);
      logic [31:0] wa;
      logic [3:0]  set;
      logic [23:0] tg;
      bit          exp_hit, exp_wb;
      int          wb0, fill0;
      wa      = {a[31:2], 2'b00};
      set     = wa[7:4];
      tg      = wa[31:8];
      exp_hit = ref_valid[set] && (ref_tag[set] == tg);
      exp_wb  = !exp_hit && ref_valid[set] && ref_dirty[set];
      wb0     = wb_count;
      fill0   = fill_count;
      cyc     = 0;
      @(negedge clk);
      addr = a; din = d; mem_read = !st; mem_write = st;
      #1;
      check_eq("hit_flag", is_hit, exp_hit);
      if (exp_hit) check_eq("hit_no_mem_req", mem_req_valid, 1'b0);
      while (!is_output_valid && cyc < 200) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check_eq("complete", is_output_valid, 1'b1);
      check_eq("zero_latency_iff_hit", cyc == 0, exp_hit);
      check_eq("wb_issued", wb_count - wb0, exp_wb);
      check_eq("fill_issued", fill_count - fill0, !exp_hit);
      if (!exp_hit) check_eq("fill_addr", last_fill_addr, {wa[31:4], 4'h0});
      if (exp_wb) check_eq("wb_addr", last_wb_addr, {ref_tag[set], set, 4'h0});
      if (st) check_eq("store_dout", dout, 32'h0);
      else    check_eq("load_dout", dout, gold_rd(wa));
      if (!exp_hit) begin
         ref_valid[set] = 1'b1;
         ref_tag[set]   = tg;
         ref_dirty[set] = 1'b0;
      end
      if (st) begin
         gold[wa]       = d;
         ref_dirty[set] = 1'b1;
      end
   endtask

   initial begin
      int cyc;
      for (int s = 0; s < 16; s++) begin
         ref_valid[s] = 1'b0;
         ref_dirty[s] = 1'b0;
         ref_tag[s]   = 24'h0;
      end
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_is_ready", is_ready, 1'b1);
      check_eq("rst_is_hit", is_hit, 1'b0);
      check_eq("rst_out_valid", is_output_valid, 1'b0);
      check_eq("rst_dout", dout, 32'h0);
      check_eq("rst_mem_req", {mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata}, 162'h0);
      @(negedge clk);
      reset = 1'b1;

      // Cold load, then hit, store, dirty eviction with a stalled writeback
      mem_word[32'h104] = 32'hDEAD_BEEF;
      gold[32'h104]     = 32'hDEAD_BEEF;
      access(1'b0, 32'h0000_0104, 32'h0, cyc);
      check_eq("cold_latency", cyc, 4);
      check_eq("cold_dout_word1", dout, 32'hDEAD_BEEF);
      access(1'b0, 32'h0000_0108, 32'h0, cyc);
      check_eq("b2b_hit_latency", cyc, 0);
      check_eq("b2b_dout_word2", dout, init_word(32'h108));
      access(1'b1, 32'h0000_0104, 32'h1234_5678, cyc);
      access(1'b0, 32'h0000_0104, 32'h0, cyc);
      check_eq("store_then_load", dout, 32'h1234_5678);
      stall_left = 5;
      access(1'b0, 32'h0000_0204, 32'h0, cyc);
      check_eq("dirty_wb_addr", last_wb_addr, 32'h100);
      check_eq("dirty_wb_word1", last_wb_wdata[63:32], 32'h1234_5678);
      check_eq("dirty_fill_addr", last_fill_addr, 32'h200);
      check_eq("stalled_miss_latency", cyc, 10);

      // Reset pulse while waiting for a fill: response must be dropped
      manual = 1'b1;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      @(negedge clk);
      addr = 32'h104; mem_read = 1'b1; mem_write = 1'b0;
      #1;
      check_eq("abort_initial_miss", is_hit, 1'b0);
      @(negedge clk);
      #1;
      check_eq("abort_fill_req", {mem_req_valid, mem_req_write, mem_req_addr}, {1'b1, 1'b0, 32'h100});
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      #1;
      check_eq("abort_fill_wait", {is_ready, mem_req_valid}, 2'b00);
      reset = 1'b0;
      mem_read = 1'b0;
      #1;
      check_eq("abort_reset_idle", is_ready, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h0000_1111};
      @(negedge clk);
      mem_resp_valid = 1'b0;
      #1;
      check_eq("abort_still_idle", {is_ready, mem_req_valid, is_output_valid}, 3'b100);
      check_eq("abort_no_install", is_hit, 1'b0);
      addr = 32'h204;
      #1;
      check_eq("abort_old_line_gone", is_hit, 1'b0);
      gold = mem_word;
      for (int s = 0; s < 16; s++) begin
         ref_valid[s] = 1'b0;
         ref_dirty[s] = 1'b0;
      end
      manual = 1'b0;
      fixed_timing = 1'b0;
      access(1'b0, 32'h0000_0104, 32'h0, cyc);
      check_eq("refill_after_abort", dout, 32'h1234_5678);

      // Randomized loads/stores over a small address pool to force conflicts
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         access(bit'($urandom_range(0, 1)), a, $urandom, cyc);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            mem_read = 1'b0; mem_write = 1'b0;
            #1;
            check_eq("idle_no_output", {is_output_valid, dout}, 33'h0);
         end
      end

      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
